// File: rtl/grf_wport_arb.sv
// grf_wport_arb: grf write-port arbiter; the W stage always wins, secondary writes
// wait in a small FIFO and drain into free cycles, with kill, pending mask and starvation stall.
module grf_wport_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_we,
    input  logic [4:0]  w_wa,
    input  logic [31:0] w_wd,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_wa,
    input  logic [31:0] s_wd,
    output logic        regwrite,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic [31:0] pend_mask,
    output logic        stall_req
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       e_wa_q [DEPTH];
    logic [4:0]       e_wa_d [DEPTH];
    logic [31:0]      e_wd_q [DEPTH];
    logic [31:0]      e_wd_d [DEPTH];
    logic [31:0]      pend_q, pend_d;
    logic [3:0]       starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             head_valid, head_live, pop, live_pop, enq, w_kill;

    always_comb begin
        head_valid = count_q != '0;
        head_live  = head_valid && live_q[head_q];
        // a dead head is discarded even while the W stage owns the port
        pop        = head_valid && (!head_live || !w_we);
        live_pop   = head_live && !w_we;
        s_ready    = count_q < CW'(DEPTH);
        enq        = s_valid && s_ready && s_wa != 5'd0 && !(w_we && s_wa == w_wa);
        w_kill     = w_we && w_wa != 5'd0;
        regwrite   = !rst && (w_we || head_live);
        wa         = rst ? 5'd0 : w_we ? w_wa : head_live ? e_wa_q[head_q] : 5'd0;
        wd         = rst ? 32'd0 : w_we ? w_wd : head_live ? e_wd_q[head_q] : 32'd0;
        head_d     = pop ? head_q + AW'(1) : head_q;
        tail_d     = enq ? tail_q + AW'(1) : tail_q;
        count_d    = count_q + CW'(enq) - CW'(pop);
        e_wa_d     = e_wa_q;
        e_wd_d     = e_wd_q;
        for (int i = 0; i < DEPTH; i++)
            live_d[i] = live_q[i] && !(w_kill && e_wa_q[i] == w_wa) && !(pop && AW'(i) == head_q);
        if (enq) begin
            live_d[tail_q] = 1'b1;
            e_wa_d[tail_q] = s_wa;
            e_wd_d[tail_q] = s_wd;
        end
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live_d[i]) pend_d[e_wa_d[i]] = 1'b1;
        // pend_q doubles as the "any live entry" flag since live entries never target r0
        starve_d = (live_pop || pend_q == '0) ? 4'd0 :
                   (head_live && w_we && starve_q != 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
        stall_d  = !live_pop && (stall_q || starve_d == 4'(STARVE_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            live_q   <= '0;
            pend_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                e_wa_q[i] <= '0;
                e_wd_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            live_q   <= live_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            e_wa_q   <= e_wa_d;
            e_wd_q   <= e_wd_d;
        end
    end

    assign pend_mask = pend_q;
    assign stall_req = stall_q;
endmodule

// File: tb/tb_grf_wport_arb.sv
// tb_grf_wport_arb: directed vector table, reset-mid-drain sequence and a random run
// checked against a queue-based reference model of the arbiter.
module tb_grf_wport_arb;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk, rst, w_we, s_valid, s_ready, regwrite, stall_req;
    logic [4:0]  w_wa, s_wa, wa;
    logic [31:0] w_wd, s_wd, wd, pend_mask;
    int total = 0, bad = 0;

    grf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd),
        .s_valid(s_valid), .s_ready(s_ready), .s_wa(s_wa), .s_wd(s_wd),
        .regwrite(regwrite), .wa(wa), .wd(wd), .pend_mask(pend_mask), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wwa;
        logic [31:0] wwd;
        logic        sv;
        logic [4:0]  swa;
        logic [31:0] swd;
        logic        e_rw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic [31:0] e_pend;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          live;
    } ent_t;

    vec_t tv[$];
    ent_t mq[$];
    int   m_starve;
    bit   m_stall;

    function automatic vec_t mk(logic we, logic [4:0] wwa, logic [31:0] wwd, logic sv, logic [4:0] swa,
                                logic [31:0] swd, logic rw, logic [4:0] ewa, logic [31:0] ewd,
                                logic rdy, logic [31:0] pend, logic stall);
        vec_t v;
        v = '{we, wwa, wwd, sv, swa, swd, rw, ewa, ewd, rdy, pend, stall};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rw, input logic [4:0] ewa, input logic [31:0] ewd,
                           input logic rdy, input logic [31:0] pend, input logic stall);
        chk({tag, " regwrite"}, 32'(regwrite), 32'(rw));
        chk({tag, " wa"}, 32'(wa), 32'(ewa));
        chk({tag, " wd"}, wd, ewd);
        chk({tag, " s_ready"}, 32'(s_ready), 32'(rdy));
        chk({tag, " pend_mask"}, pend_mask, pend);
        chk({tag, " stall_req"}, 32'(stall_req), 32'(stall));
    endtask

    task automatic drive(input logic we, input logic [4:0] wwa, input logic [31:0] wwd,
                         input logic sv, input logic [4:0] swa, input logic [31:0] swd);
        w_we = we; w_wa = wwa; w_wd = wwd; s_valid = sv; s_wa = swa; s_wd = swd;
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].wa] = 1'b1;
        return p;
    endfunction

    task automatic m_check(input string tag);
        bit hl = mq.size() > 0 && mq[0].live;
        logic [4:0]  ewa = w_we ? w_wa : hl ? mq[0].wa : 5'd0;
        logic [31:0] ewd = w_we ? w_wd : hl ? mq[0].wd : 32'd0;
        chk_all(tag, w_we || hl, ewa, ewd, mq.size() < DEPTH, m_pend(), m_stall);
    endtask

    task automatic m_step();
        bit hl  = mq.size() > 0 && mq[0].live;
        bit lp  = hl && !w_we;
        bit pp  = mq.size() > 0 && (!mq[0].live || !w_we);
        bit rdy = mq.size() < DEPTH;
        if (lp || m_pend() == 0) m_starve = 0;
        else if (hl && w_we && m_starve < SMAX) m_starve++;
        m_stall = !lp && (m_stall || m_starve == SMAX);
        if (w_we && w_wa != 0) foreach (mq[i]) if (mq[i].wa == w_wa) mq[i].live = 0;
        if (pp) void'(mq.pop_front());
        if (s_valid && rdy && s_wa != 0 && !(w_we && s_wa == w_wa)) mq.push_back('{s_wa, s_wd, 1'b1});
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        // single accept, one-cycle latency
        tv.push_back(mk(0, 0, 0, 1, 8, 32'h12345678, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 32'h12345678, 1, 32'h100, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // fill while blocked, full FIFO refuses, starvation stall then drain
        tv.push_back(mk(1, 9, 32'h99, 1, 3, 32'h33, 1, 9, 32'h99, 1, 0, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 4, 32'h44, 1, 9, 32'h99, 1, 32'h8, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 6, 32'h66, 1, 9, 32'h99, 0, 32'h18, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 6, 32'h66, 1, 9, 32'h99, 0, 32'h18, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 6, 32'h66, 1, 9, 32'h99, 0, 32'h18, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 0, 32'h18, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 32'h10, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // kill of a queued entry by a newer W write
        tv.push_back(mk(0, 0, 0, 1, 5, 32'hAAAA0000, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 5, 32'h1, 0, 0, 0, 1, 5, 32'h1, 1, 32'h20, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // same-cycle same-address collision drops the secondary
        tv.push_back(mk(1, 7, 32'h7000, 1, 7, 32'h77, 1, 7, 32'h7000, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        // r0 target is consumed and dropped
        tv.push_back(mk(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 1, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        foreach (tv[i]) begin
            drive(tv[i].we, tv[i].wwa, tv[i].wwd, tv[i].sv, tv[i].swa, tv[i].swd);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), tv[i].e_rw, tv[i].e_wa, tv[i].e_wd,
                    tv[i].e_rdy, tv[i].e_pend, tv[i].e_stall);
            @(posedge clk); #1;
        end

        // reset asserted mid-drain with two queued entries
        drive(1, 1, 32'h11, 1, 10, 32'hA);
        @(posedge clk); #1;
        drive(1, 1, 32'h11, 1, 11, 32'hB);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("drain", 1, 10, 32'hA, 0, 32'hC00, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all("rst_mid", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 1, 0, 0);
        end

        // random run against the reference model
        rst = 1'b1;
        mq.delete();
        m_starve = 0;
        m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            drive(!m_stall && ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            @(negedge clk);
            m_check($sformatf("rnd%0d", n));
            m_step();
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grf_wport_arb.md
Name: grf_wport_arb

Overview:
- Arbitrates the single grf write port between two sources.
  - Primary: pipeline W stage, which has absolute priority and is never stalled by this block.
  - Secondary: multi-cycle result sources, e.g. the mult/div unit and late coprocessor results.
- Secondary writes are queued in a small FIFO and drained into free write-port cycles.
- Exports a pending-address mask so the hazard unit can stall readers of queued registers.
- Raises a stall request to force a bubble when the secondary queue is starved.

Parameters:
- DEPTH, 2, secondary FIFO entries (power of two, 2..8).
- STARVE_MAX, 4, consecutive blocked cycles before stall_req asserts (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_we  in  1  W-stage write enable.
- w_wa  in  5  W-stage destination register.
- w_wd  in  32  W-stage write data.
- s_valid  in  1  secondary write request.
- s_ready  out  1  secondary request accepted this cycle when s_valid=1.
- s_wa  in  5  secondary destination register.
- s_wd  in  32  secondary write data.
- regwrite  out  1  to grf regwrite.
- wa  out  5  to grf wa.
- wd  out  32  to grf wd.
- pend_mask  out  32  bit i=1 if a live queued entry targets register i; bit 0 always 0.
- stall_req  out  1  request to pipeline to insert one W-stage bubble.

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; all entry live bits cleared; starve counter = 0.
  - stall_req=0, pend_mask=0, s_ready=1, regwrite=0, wa=0, wd=0.
  - A reset asserted mid-drain discards all queued writes; no partial write occurs.
- Port mux (combinational):
  - If w_we=1: regwrite=1, wa=w_wa, wd=w_wd.
  - Else if the FIFO head is live: regwrite=1, wa/wd = head entry; head pops at the clock edge.
  - Else regwrite=0, wa=0, wd=0.
- Dead head: a non-live head pops on any cycle, including cycles where w_we=1, with no write.
- Enqueue:
  - s_ready = (count < DEPTH), derived from registered count only.
  - There is no same-cycle pass-through. Minimum secondary latency is 1 cycle from acceptance to grf write.
  - An accepted request with s_wa=0 is consumed and dropped; it is not enqueued.
  - An accepted request with s_wa == w_wa while w_we=1 in the same cycle is dropped. The W-stage write is architecturally newer.
- Ordering / kill:
  - Queued entries are older than any W-stage write.
  - When w_we=1 and w_wa!=0, every live entry with wa==w_wa has its live bit cleared at that edge and never writes.
  - Multiple live entries with the same address drain in FIFO order.
- pend_mask: OR of one-hot(wa) over live entries, registered, updated the same edge as enqueue, pop or kill.
- Simultaneous enqueue and pop in one cycle: count is unchanged; ordering is preserved.
- Starvation:
  - The counter increments each cycle that a live head exists and w_we=1.
  - It clears on any live-head pop or when the FIFO holds no live entry. It saturates at STARVE_MAX.
  - stall_req is registered: it asserts the cycle after the counter reaches STARVE_MAX and stays high until the next live-head pop, then deasserts at that edge.
  - The pipeline guarantees w_we=0 on the cycle after stall_req first rises.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.

Test Plan:
1. Reset release, s_valid=1, s_wa=8, s_wd=0x12345678, w_we=0 → s_ready=1; next cycle regwrite=1, wa=8, wd=0x12345678, pend_mask bit 8 high for exactly one cycle.
2. Fill DEPTH=2 (wa=3, then wa=4) while w_we=1 with w_wa=9 held → s_ready=0 after the second accept. pend_mask=0x18. stall_req rises after 4 blocked cycles. Drop w_we → wa=3 written, then wa=4 written, stall_req falls.
3. Queue wa=5 data 0xAAAA0000, then W-stage writes wa=5 data 0x1 → entry killed, pend_mask bit 5 clears. Head pops with regwrite=0; register 5 final value 0x1.
4. Same-cycle s_valid with s_wa=7 and w_we=1 with w_wa=7 → secondary dropped; only w_wd written; pend_mask stays 0.
5. s_wa=0 accepted → no enqueue, no write, pend_mask=0, count unchanged.
6. Assert rst with 2 live entries mid-drain → regwrite=0 immediately; s_ready=1, pend_mask=0, stall_req=0; no queued write appears after release.
